// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in parallel-out frame receiver.
// Optional even-parity support is selected with the SIPO_PARITY_EN macro.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP,
        ST_BREAK  = S_BREAK
    } state_t;

endpackage

// File: rtl/sipo_shift.sv
// Right-shifting capture register: new bits enter at the MSB so the first
// bit received ends up in bit 0 after WIDTH shifts.
module sipo_shift
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even
// parity (SIPO_PARITY_EN), stop bit; registered word plus one-cycle strobes.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             clr_c;
    logic             shift_c;
`ifdef SIPO_PARITY_EN
    logic             par_bit;
`endif

    // The start sample clears the capture register; every DATA sample shifts.
    assign clr_c   = bit_en && (state == ST_IDLE) && !sin;
    assign shift_c = bit_en && (state == ST_DATA);

    sipo_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr_c),
        .shift_en (shift_c),
        .sin      (sin),
        .q        (shreg)
    );

    // Frame FSM with registered word, strobes and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!sin) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
`ifdef SIPO_PARITY_EN
                    ST_PARITY: begin
                        par_bit <= sin;
                        state   <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (sin) begin
                            dout       <= shreg;
                            dout_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
`ifdef SIPO_PARITY_EN
                            parity_err <= par_bit ^ (^shreg);
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end
                    // A held-low line after a bad stop bit is not a start bit.
                    ST_BREAK: begin
                        if (sin) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
